// File: rtl/keccak_pkg.sv
// Shared constants, FSM state encoding and byte-lane helper for the Keccak
// message packer.
package keccak_pkg;

  localparam int WORD_BYTES = 8;
  localparam int WORD_W     = 64;

  typedef enum logic [1:0] {
    FILL,
    SEND,
    SEND_PAD,
    WAIT_OUT
  } packer_state_e;

  // Byte n of a word sits at [63-8n -: 8]; its lsb is 8*(7-n) = {~n, 3'b000}.
  function automatic logic [5:0] lane_lsb(input logic [2:0] n);
    return {~n, 3'b000};
  endfunction

endpackage

// File: rtl/keccak_byte_acc.sv
// Byte accumulator for the message packer: packs bytes MSB-first into a
// 64-bit word and tracks how many bytes have been written.
module keccak_byte_acc
  import keccak_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] merged,
  output logic [3:0]        count,
  output logic              full
);

  logic [WORD_W-1:0] acc;
  logic [3:0]        count_inc;

  // merged/full describe the word as it would look with `data` included,
  // so the owner can launch a word in the same cycle the last byte arrives.
  assign count_inc = count + 4'd1;
  assign full      = (count_inc == 4'(WORD_BYTES));
  assign merged    = acc | (WORD_W'(data) << lane_lsb(count[2:0]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= merged;
      count <= count_inc;
    end
  end

endmodule

// File: rtl/keccak_msg_packer.sv
// Byte-stream to 64-bit word packer feeding the SHA3/Keccak core, with
// buffer_full back-pressure and optional hold-off until the digest is ready.
module keccak_msg_packer
  import keccak_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit WAIT_DIGEST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [WORD_W-1:0] in,
  output logic              in_ready,
  output logic              is_last,
  output logic [2:0]        byte_num,
  input  logic              buffer_full,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  packer_state_e     state;
  logic              pad;
  logic              take;
  logic              word_ends;
  logic              acc_clear;
  logic              acc_full;
  logic [3:0]        acc_count;
  logic [WORD_W-1:0] merged;

  assign take      = s_valid && s_ready;
  assign word_ends = take && (s_last || acc_full);
  assign acc_clear = word_ends || ((state == WAIT_OUT) && out_ready);

  keccak_byte_acc u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .load   (take),
    .data   (s_data),
    .merged (merged),
    .count  (acc_count),
    .full   (acc_full)
  );

  // A message ending exactly on a word boundary needs an extra all-zero
  // word carrying is_last; `pad` remembers that while the full word waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      pad      <= 1'b0;
      in       <= '0;
      in_ready <= 1'b0;
      is_last  <= 1'b0;
      byte_num <= 3'd0;
      s_ready  <= 1'b1;
      word_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      if (in_ready && !buffer_full && (word_cnt != '1))
        word_cnt <= word_cnt + CNT_W'(1);

      case (state)
        FILL: begin
          busy <= take || (acc_count != 4'd0);
          if (word_ends) begin
            state    <= SEND;
            s_ready  <= 1'b0;
            in       <= merged;
            in_ready <= 1'b1;
            is_last  <= s_last && !acc_full;
            byte_num <= (s_last && !acc_full) ? (acc_count[2:0] + 3'd1) : 3'd0;
            pad      <= s_last && acc_full;
          end
        end
        SEND: begin
          if (!buffer_full) begin
            if (pad) begin
              state    <= SEND_PAD;
              pad      <= 1'b0;
              in       <= '0;
              is_last  <= 1'b1;
              byte_num <= 3'd0;
            end else begin
              in_ready <= 1'b0;
              is_last  <= 1'b0;
              byte_num <= 3'd0;
              if (is_last && WAIT_DIGEST) begin
                state <= WAIT_OUT;
              end else begin
                state   <= FILL;
                s_ready <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
        end
        SEND_PAD: begin
          if (!buffer_full) begin
            in_ready <= 1'b0;
            is_last  <= 1'b0;
            byte_num <= 3'd0;
            if (WAIT_DIGEST) begin
              state <= WAIT_OUT;
            end else begin
              state   <= FILL;
              s_ready <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        WAIT_OUT: begin
          if (out_ready) begin
            state   <= FILL;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= FILL;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_msg_packer.sv
// Randomized scoreboard bench for keccak_msg_packer: messages are split into
// expected core words up front and a negedge monitor checks every handshake.
module tb_keccak_msg_packer;

  localparam int CNT_W = 5;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [2:0]  bnum;
    bit          fin;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [63:0]      core_in;
  logic             in_ready;
  logic             is_last;
  logic [2:0]       byte_num;
  logic             buffer_full;
  logic             out_ready;
  logic [CNT_W-1:0] word_cnt;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   exp_cnt = 0;
  int   partial = 0;
  bit   blocked = 0;
  bit   release_now = 0;
  bit   prev_stall = 0;
  logic [63:0] prev_in;
  logic [4:0]  prev_ctl;
  bit   random_bf = 0;
  bit   noise_en = 0;
  int   stall_req = 0;
  int   or_delay = 0;

  keccak_msg_packer #(.CNT_W(CNT_W), .WAIT_DIGEST(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .in          (core_in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out_ready   (out_ready),
    .word_cnt    (word_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event required=none at %0t", name, $time);
  endtask

  // Reference model: split the message into 8-byte words, first byte in the
  // top lane; a message of whole words gets an extra zero word as its last.
  function automatic void push_expected(input logic [7:0] msg[$]);
    int   n = msg.size();
    int   nw = (n + 7) / 8;
    int   rem = n % 8;
    exp_t e;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < n) e.data[63 - 8 * k -: 8] = msg[w * 8 + k];
      e.last = (w == nw - 1) && (rem != 0);
      e.bnum = e.last ? 3'(rem) : 3'd0;
      e.fin  = e.last;
      sb.push_back(e);
    end
    if (rem == 0) begin
      e.data = '0;
      e.last = 1'b1;
      e.bnum = 3'd0;
      e.fin  = 1'b1;
      sb.push_back(e);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit last);
    int waited = 0;
    bit took = 0;
    s_data  = b;
    s_valid = 1'b1;
    s_last  = last;
    do begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!took && waited < 2000);
    if (!took) report_fail("byte_timeout");
    s_valid = 1'b0;
    s_last  = 1'($urandom);
    s_data  = 8'($urandom);
  endtask

  task automatic apply_stimulus(input logic [7:0] msg[$], input int max_gap);
    push_expected(msg);
    for (int i = 0; i < msg.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        s_last = 1'($urandom);
        @(posedge clk);
        #1;
      end
      send_byte(msg[i], i == msg.size() - 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || blocked) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) report_fail("drain_timeout");
  endtask

  // Core-side back-pressure: directed stalls on a presented word, else noise.
  always begin
    @(posedge clk);
    #1;
    if (stall_req > 0 && in_ready) begin
      buffer_full = 1'b1;
      stall_req--;
    end else begin
      buffer_full = random_bf ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Digest: pulse out_ready a few cycles after a message's final word; noise
  // at other times must be ignored by the packer.
  always begin
    @(posedge clk);
    #1;
    if (blocked) begin
      if (or_delay == 0) out_ready = 1'b1;
      else begin
        out_ready = 1'b0;
        or_delay--;
      end
    end else begin
      out_ready = noise_en ? 1'($urandom) : 1'b0;
      or_delay  = $urandom_range(0, 4);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_cnt     = 0;
      partial     = 0;
      blocked     = 0;
      release_now = 0;
      prev_stall  = 0;
    end else begin
      if (blocked) check_output("s_ready_wait", 64'(s_ready), 64'd0);
      if (release_now) begin
        check_output("s_ready_release", 64'(s_ready), 64'd1);
        release_now = 0;
      end
      check_output("word_cnt", 64'(word_cnt), 64'(exp_cnt));
      check_output("busy", 64'(busy), 64'(in_ready || blocked || partial != 0));
      if (!is_last) check_output("byte_num_zero", 64'(byte_num), 64'd0);
      if (prev_stall) begin
        check_output("stall_in", core_in, prev_in);
        check_output("stall_ctl", 64'({in_ready, is_last, byte_num}), 64'(prev_ctl));
      end
      if (blocked && out_ready) begin
        blocked     = 0;
        release_now = 1;
      end
      if (in_ready && !buffer_full) begin
        if (sb.size() == 0) report_fail("unexpected_word");
        else begin
          e = sb.pop_front();
          check_output("word_data", core_in, e.data);
          check_output("word_is_last", 64'(is_last), 64'(e.last));
          check_output("word_byte_num", 64'(byte_num), 64'(e.bnum));
          if (e.fin) blocked = 1;
        end
        if (exp_cnt < SAT) exp_cnt++;
      end
      if (s_valid && s_ready) partial = (s_last || partial == 7) ? 0 : partial + 1;
      prev_stall = in_ready && buffer_full;
      prev_in    = core_in;
      prev_ctl   = {in_ready, is_last, byte_num};
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] m[$];
    reset       = 1'b1;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = 8'h00;
    buffer_full = 1'b0;
    out_ready   = 1'b0;
    #2;
    check_output("rst_in", core_in, 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_is_last", 64'(is_last), 64'd0);
    check_output("rst_word_cnt", 64'(word_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_output("rst_s_ready", 64'(s_ready), 64'd1);
    check_output("rst_busy", 64'(busy), 64'd0);
    noise_en = 1;

    $display("[TB] short message abc");
    m = '{8'h61, 8'h62, 8'h63};
    apply_stimulus(m, 0);
    wait_idle();

    $display("[TB] exact 8-byte message with pad word");
    m = {};
    for (int i = 0; i < 8; i++) m.push_back(8'(i));
    apply_stimulus(m, 0);
    wait_idle();

    $display("[TB] 12-byte message with a 5-cycle stall");
    stall_req = 5;
    m = {};
    for (int i = 0; i < 12; i++) m.push_back(8'($urandom));
    apply_stimulus(m, 0);
    wait_idle();

    $display("[TB] reset after 5 bytes of a message");
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    reset = 1'b1;
    #1;
    check_output("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check_output("mid_rst_s_ready", 64'(s_ready), 64'd1);
    check_output("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
    check_output("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    m = '{8'hFF};
    apply_stimulus(m, 0);

    $display("[TB] 17-byte message with idle gaps and back-pressure");
    random_bf = 1;
    m = {};
    for (int i = 0; i < 17; i++) m.push_back(8'($urandom));
    apply_stimulus(m, 3);

    $display("[TB] random back-to-back messages");
    for (int k = 0; k < 30; k++) begin
      m = {};
      for (int i = 0; i < $urandom_range(1, 24); i++) m.push_back(8'($urandom));
      apply_stimulus(m, 2);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check_output("word_cnt_saturated", 64'(word_cnt), 64'(SAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
